escritor_digitos: RTL and testbench

Display-data writer feeding the VGA digit renderer. It sweeps the time/date/timer positions in order and, for each one, fetches the BCD byte from the RTC register controller with a req/ack handshake. It then presents the byte on `DIR_DATO`/`POSICION` with a one-cycle `RD` strobe, which is the write side of the interface the renderer's input manager consumes. It sits between the RTC bus controller and the VGA text path and refreshes the whole screen image periodically.

---
 rtl/escritor_digitos.sv | 190 +++++++++++++++++++
 tb/tb_escritor_digitos.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escritor_digitos.sv
// escritor_digitos: sweeps the display positions, fetches each packed-BCD
// byte from the RTC register controller over a req/ack handshake, and
// writes it to the VGA digit renderer with a one-cycle RD strobe.
//
// Optional feature macro: ESCRITOR_BCD_CHECK_EN. When it is defined, the
// module validates each BCD nibble and zeroes any invalid one.
//
// Ports:
//   reloj      in   system clock, rising edge
//   resetM     in   synchronous active-high reset
//   inicio     in   level enable for sweeps
//   ack_rtc    in   RTC acknowledge, dato_rtc valid in the same cycle
//   dato_rtc   in   RTC byte (packed BCD)
//   req_rtc    out  read request, held until ack or timeout
//   dir_rtc    out  RTC register address of the current position
//   DIR_DATO   out  BCD byte for the renderer
//   POSICION   out  screen position of DIR_DATO
//   RD         out  one-cycle write strobe
//   ocupado    out  high while a sweep is in progress
//   error_rtc  out  sticky error (timeout / invalid BCD)
//
// state   | meaning
// IDLE    | waiting for inicio to start a sweep
// ESPERAR | request outstanding, waiting for ack or timeout
// ESCRITO | RD strobe cycle, then advance position or finish sweep
// PAUSA   | PERIODO idle cycles between sweeps
module escritor_digitos #(
  parameter int N_POS   = 9,
  parameter int PERIODO = 1_000_000,
  parameter int TIMEOUT = 255
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       inicio,
  input  logic       ack_rtc,
  input  logic [7:0] dato_rtc,
  output logic       req_rtc,
  output logic [7:0] dir_rtc,
  output logic [7:0] DIR_DATO,
  output logic [3:0] POSICION,
  output logic       RD,
  output logic       ocupado,
  output logic       error_rtc
);

  localparam int PER_W = ($clog2(PERIODO + 1) > 20) ? $clog2(PERIODO + 1) : 20;
  localparam logic [3:0]       LAST_POS = 4'(N_POS - 1);
  localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT);
  localparam logic [PER_W-1:0] PER_LIM  = PER_W'(PERIODO);

  typedef enum logic [1:0] {IDLE, ESPERAR, ESCRITO, PAUSA} estado_t;

  estado_t          estado, estado_d;
  logic [3:0]       pos, pos_d;
  logic [7:0]       cnt_to, cnt_to_d, cnt_to_inc;
  logic [PER_W-1:0] cnt_per, cnt_per_d, cnt_per_inc;
  logic             req_d, rd_d, ocupado_d, error_d;
  logic [7:0]       dir_d, dato_d;
  logic [3:0]       posicion_d;
  logic [7:0]       dato_chk;
  logic             bcd_bad;
  logic             ack_ok;

  function automatic logic [7:0] map_dir(input logic [3:0] p);
    case (p)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

`ifdef ESCRITOR_BCD_CHECK_EN
  logic [7:0] dato_msk;
  always_comb begin
    dato_msk = dato_rtc;
    // hora bytes carry 12/24h flags in [7:6]
    if (pos == 4'd2 || pos == 4'd8) dato_msk[7:6] = 2'b00;
    bcd_bad  = (dato_msk[7:4] > 4'd9) || (dato_msk[3:0] > 4'd9);
    dato_chk = dato_msk;
    if (dato_msk[7:4] > 4'd9) dato_chk[7:4] = 4'd0;
    if (dato_msk[3:0] > 4'd9) dato_chk[3:0] = 4'd0;
  end
`else
  assign dato_chk = dato_rtc;
  assign bcd_bad  = 1'b0;
`endif

  assign ack_ok      = ack_rtc && req_rtc;
  assign cnt_to_inc  = (cnt_to == 8'hFF) ? cnt_to : cnt_to + 8'd1;
  assign cnt_per_inc = cnt_per + PER_W'(1);

  always_ff @(posedge reloj) begin
    if (resetM) begin
      estado    <= IDLE;
      pos       <= 4'd0;
      cnt_to    <= 8'd0;
      cnt_per   <= '0;
      req_rtc   <= 1'b0;
      dir_rtc   <= 8'h00;
      DIR_DATO  <= 8'h00;
      POSICION  <= 4'd0;
      RD        <= 1'b0;
      ocupado   <= 1'b0;
      error_rtc <= 1'b0;
    end else begin
      estado    <= estado_d;
      pos       <= pos_d;
      cnt_to    <= cnt_to_d;
      cnt_per   <= cnt_per_d;
      req_rtc   <= req_d;
      dir_rtc   <= dir_d;
      DIR_DATO  <= dato_d;
      POSICION  <= posicion_d;
      RD        <= rd_d;
      ocupado   <= ocupado_d;
      error_rtc <= error_d;
    end
  end

  always_comb begin
    estado_d   = estado;
    pos_d      = pos;
    cnt_to_d   = cnt_to;
    cnt_per_d  = cnt_per;
    req_d      = req_rtc;
    dir_d      = dir_rtc;
    dato_d     = DIR_DATO;
    posicion_d = POSICION;
    rd_d       = 1'b0;
    ocupado_d  = ocupado;
    error_d    = error_rtc;
    case (estado)
      IDLE: begin
        if (inicio) begin
          pos_d     = 4'd0;
          cnt_to_d  = 8'd0;
          req_d     = 1'b1;
          dir_d     = map_dir(4'd0);
          ocupado_d = 1'b1;
          estado_d  = ESPERAR;
        end
      end
      ESPERAR: begin
        cnt_to_d = cnt_to_inc;
        // ack has priority over a timeout landing in the same cycle
        if (ack_ok) begin
          dato_d     = dato_chk;
          posicion_d = pos;
          rd_d       = 1'b1;
          req_d      = 1'b0;
          if (bcd_bad) error_d = 1'b1;
          estado_d   = ESCRITO;
        end else if (cnt_to_inc >= TO_LIM) begin
          dato_d     = 8'h00;
          posicion_d = pos;
          rd_d       = 1'b1;
          req_d      = 1'b0;
          error_d    = 1'b1;
          estado_d   = ESCRITO;
        end
      end
      ESCRITO: begin
        if (pos != LAST_POS) begin
          pos_d    = pos + 4'd1;
          dir_d    = map_dir(pos + 4'd1);
          req_d    = 1'b1;
          cnt_to_d = 8'd0;
          estado_d = ESPERAR;
        end else begin
          ocupado_d = 1'b0;
          cnt_per_d = '0;
          estado_d  = PAUSA;
        end
      end
      PAUSA: begin
        cnt_per_d = cnt_per_inc;
        if (cnt_per_inc >= PER_LIM) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_escritor_digitos.sv
// Directed testbench for escritor_digitos (N_POS=9, PERIODO=10, TIMEOUT=255).
// A simple RTC responder and output logger run inside the cycle task.
module tb_escritor_digitos;

  logic       reloj = 1'b0;
  logic       resetM, inicio, ack_rtc;
  logic [7:0] dato_rtc;
  logic       req_rtc, RD, ocupado, error_rtc;
  logic [7:0] dir_rtc, DIR_DATO;
  logic [3:0] POSICION;

  escritor_digitos #(.N_POS(9), .PERIODO(10), .TIMEOUT(255)) dut (
    .reloj(reloj), .resetM(resetM), .inicio(inicio), .ack_rtc(ack_rtc),
    .dato_rtc(dato_rtc), .req_rtc(req_rtc), .dir_rtc(dir_rtc),
    .DIR_DATO(DIR_DATO), .POSICION(POSICION), .RD(RD), .ocupado(ocupado),
    .error_rtc(error_rtc)
  );

  always #5 reloj = ~reloj;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];
  logic [7:0] exp_dir [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  int   drop_pos, slow_pos, slow_delay;
  bit   stray_ack;
  int   k;
  logic req_prev, rd_prev;
  int   rd_wide, ocu_cycles;
  int   req_cycles [0:15];
  logic [3:0] rd_pos_q[$];
  logic [7:0] rd_dat_q[$];
  logic [7:0] dir_q[$];

  function automatic int addr2pos(input logic [7:0] a);
    case (a)
      8'h21: return 0;
      8'h22: return 1;
      8'h23: return 2;
      8'h24: return 3;
      8'h25: return 4;
      8'h26: return 5;
      8'h41: return 6;
      8'h42: return 7;
      8'h43: return 8;
      default: return 15;
    endcase
  endfunction

  task automatic cycle();
    int p;
    @(negedge reloj);
    if (RD) begin
      rd_pos_q.push_back(POSICION);
      rd_dat_q.push_back(DIR_DATO);
      if (rd_prev) rd_wide++;
    end
    rd_prev = RD;
    if (ocupado) ocu_cycles++;
    p = addr2pos(dir_rtc);
    if (req_rtc && !req_prev) begin
      dir_q.push_back(dir_rtc);
      k = 0;
    end else if (req_rtc) begin
      k++;
    end
    if (req_rtc) req_cycles[p]++;
    if (stray_ack) begin
      ack_rtc = 1'b1; dato_rtc = 8'h77;
    end else if (req_rtc && p != drop_pos && k >= ((p == slow_pos) ? slow_delay : 0)) begin
      ack_rtc = 1'b1; dato_rtc = mem[dir_rtc];
    end else begin
      ack_rtc = 1'b0; dato_rtc = 8'h00;
    end
    req_prev = req_rtc;
  endtask

  task automatic clear_log();
    rd_pos_q.delete(); rd_dat_q.delete(); dir_q.delete();
    rd_wide = 0; ocu_cycles = 0;
    for (int i = 0; i < 16; i++) req_cycles[i] = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h59;
    drop_pos = -1; slow_pos = -1; slow_delay = 0; stray_ack = 1'b0;
    inicio = 1'b0; resetM = 1'b1;
    cycle(); cycle();
    resetM = 1'b0;
    clear_log();
  endtask

  task automatic run_sweep(input bit hold, output bit done);
    bit seen;
    seen = 1'b0; done = 1'b0;
    inicio = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (ocupado) begin
        seen = 1'b1;
        if (!hold) inicio = 1'b0;
      end else if (seen) begin
        done = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL sweep_done: sweep did not finish within budget, required completion");
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_tests++;
    if ({req_rtc, dir_rtc, DIR_DATO, POSICION, RD, ocupado, error_rtc} !== 24'h0) begin
      n_fail++;
      $display("FAIL %s: req=%b dir=%h dato=%h pos=%0d rd=%b ocu=%b err=%b, required all 0",
               tag, req_rtc, dir_rtc, DIR_DATO, POSICION, RD, ocupado, error_rtc);
    end
  endtask

  task automatic check_writes(input string tag, input int bad_pos, input logic [7:0] bad_val);
    logic [7:0] e;
    n_tests++;
    if (rd_pos_q.size() != 9) begin
      n_fail++;
      $display("FAIL %s_count: %0d RD pulses, required 9", tag, rd_pos_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        e = (i == bad_pos) ? bad_val : 8'h59;
        n_tests++;
        if (rd_pos_q[i] !== 4'(i) || rd_dat_q[i] !== e) begin
          n_fail++;
          $display("FAIL %s_write%0d: pos=%0d dato=%h, required pos=%0d dato=%h",
                   tag, i, rd_pos_q[i], rd_dat_q[i], i, e);
        end
      end
    end
    n_tests++;
    if (rd_wide != 0) begin
      n_fail++;
      $display("FAIL %s_rd_width: %0d wide RD pulses, required 0", tag, rd_wide);
    end
  endtask

  task automatic test_reset();
    resetM = 1'b1; inicio = 1'b0; ack_rtc = 1'b0; dato_rtc = 8'h00;
    req_prev = 1'b0; rd_prev = 1'b0; k = 0;
    do_reset();
    check_outputs_zero("reset");
  endtask

  task automatic test_sweep();
    bit done;
    do_reset();
    run_sweep(1'b0, done);
    check_writes("sweep", -1, 8'h00);
    n_tests++;
    if (dir_q.size() != 9) begin
      n_fail++;
      $display("FAIL sweep_dir_count: %0d requests, required 9", dir_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (dir_q[i] !== exp_dir[i]) begin
          n_fail++;
          $display("FAIL sweep_dir%0d: dir=%h, required %h", i, dir_q[i], exp_dir[i]);
        end
      end
    end
    n_tests++;
    if (ocu_cycles != 18) begin
      n_fail++;
      $display("FAIL sweep_busy_len: ocupado %0d cycles, required 18", ocu_cycles);
    end
    n_tests++;
    if (error_rtc !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_error: error_rtc=%b, required 0", error_rtc);
    end
  endtask

  task automatic test_timeout();
    bit done;
    do_reset();
    drop_pos = 3;
    run_sweep(1'b0, done);
    check_writes("timeout", 3, 8'h00);
    n_tests++;
    if (req_cycles[3] != 255) begin
      n_fail++;
      $display("FAIL timeout_len: req high %0d cycles, required 255", req_cycles[3]);
    end
    n_tests++;
    if (error_rtc !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_error: error_rtc=%b, required 1", error_rtc);
    end
  endtask

  task automatic test_bcd_check();
    bit done;
    logic [7:0] e1, e2;
    logic       ee;
`ifdef ESCRITOR_BCD_CHECK_EN
    e1 = 8'h50; e2 = 8'h12; ee = 1'b1;
`else
    e1 = 8'h5C; e2 = 8'h92; ee = 1'b0;
`endif
    do_reset();
    mem[8'h22] = 8'h5C;
    mem[8'h23] = 8'h92;
    run_sweep(1'b0, done);
    n_tests++;
    if (rd_dat_q.size() != 9) begin
      n_fail++;
      $display("FAIL bcd_count: %0d RD pulses, required 9", rd_dat_q.size());
    end else begin
      n_tests++;
      if (rd_dat_q[1] !== e1) begin
        n_fail++;
        $display("FAIL bcd_min: dato=%h, required %h", rd_dat_q[1], e1);
      end
      n_tests++;
      if (rd_dat_q[2] !== e2) begin
        n_fail++;
        $display("FAIL bcd_hora: dato=%h, required %h", rd_dat_q[2], e2);
      end
    end
    n_tests++;
    if (error_rtc !== ee) begin
      n_fail++;
      $display("FAIL bcd_error: error_rtc=%b, required %b", error_rtc, ee);
    end
  endtask

  task automatic test_ack_at_timeout();
    bit done;
    do_reset();
    slow_pos = 0; slow_delay = 254;
    mem[8'h21] = 8'h59;
    run_sweep(1'b0, done);
    check_writes("ack_tie", -1, 8'h00);
    n_tests++;
    if (error_rtc !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_tie_error: error_rtc=%b, required 0", error_rtc);
    end
  endtask

  task automatic test_stray_ack();
    bit done;
    do_reset();
    run_sweep(1'b0, done);
    clear_log();
    stray_ack = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    stray_ack = 1'b0;
    cycle(); cycle();
    n_tests++;
    if (rd_pos_q.size() != 0 || req_rtc !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: %0d RD pulses req=%b, required 0 pulses req=0",
               rd_pos_q.size(), req_rtc);
    end
  endtask

  task automatic test_reset_mid();
    bit done, found;
    do_reset();
    drop_pos = 4; found = 1'b0;
    inicio = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (req_rtc && dir_rtc == 8'h25) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_reach: position 4 request not seen, required within 200 cycles");
    end
    for (int i = 0; i < 3; i++) cycle();
    resetM = 1'b1;
    cycle();
    resetM = 1'b0;
    check_outputs_zero("midreset");
    drop_pos = -1;
    clear_log();
    run_sweep(1'b0, done);
    n_tests++;
    if (dir_q.size() == 0 || rd_pos_q.size() == 0 || dir_q[0] !== 8'h21 || rd_pos_q[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_restart: first dir=%h first pos=%0d, required 21 and 0",
               (dir_q.size() != 0) ? dir_q[0] : 8'hxx, (rd_pos_q.size() != 0) ? rd_pos_q[0] : 4'hx);
    end
    check_writes("midreset", -1, 8'h00);
  endtask

  task automatic test_periodo();
    bit done;
    int gap;
    do_reset();
    run_sweep(1'b1, done);
    gap = 1;
    for (int i = 0; i < 100 && !req_rtc; i++) begin
      cycle();
      if (!req_rtc) gap++;
    end
    inicio = 1'b0;
    n_tests++;
    if (gap != 11) begin
      n_fail++;
      $display("FAIL periodo_gap: next req %0d cycles after ocupado fell, required 11", gap);
    end
    n_tests++;
    if (dir_rtc !== 8'h21 || ocupado !== 1'b1) begin
      n_fail++;
      $display("FAIL periodo_restart: dir=%h ocupado=%b, required 21 and 1", dir_rtc, ocupado);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_bcd_check();
    test_ack_at_timeout();
    test_stray_ack();
    test_reset_mid();
    test_periodo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
